// File: rtl/pong_pkg.sv
// Shared definitions for the pong game-level sequencer.
// Holds the FSM state encoding, the coordinate widths and the default
// screen/ball/paddle geometry and scoring constants used by the
// controller and its collision block.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Coordinate widths of the ball / paddle position buses.
  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  // Every geometry comparison is done at this width so that sums of a
  // coordinate and a size can never wrap.
  localparam int CMP_W = 11;

  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_SCREEN_H    = 480;
  localparam int DEF_BALL_SZ     = 8;
  localparam int DEF_PAD_H       = 64;
  localparam int DEF_PAD_W       = 8;
  localparam int DEF_PAD_XL      = 16;
  localparam int DEF_PAD_XR      = 616;
  localparam int DEF_WIN_SCORE   = 7;
  localparam int DEF_PAUSE_TICKS = 60;

endpackage

// File: rtl/pong_collide.sv
// Purely combinational collision / miss detector.
// Ports:
//   ball_x, ball_y   : ball top-left corner
//   pad_l_y, pad_r_y : paddle top edges
//   wall_hit         : ball touches the top or bottom wall
//   wall_clear       : ball lies strictly inside the vertical band
//   pad_hit          : ball overlaps either paddle
//   pad_clear        : ball x range is outside both paddle columns
//   miss_l           : ball reached the left edge (right player scores)
//   miss_r           : ball reached the right edge (left player scores)
module pong_collide
  import pong_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int BALL_SZ  = DEF_BALL_SZ,
  parameter int PAD_H    = DEF_PAD_H,
  parameter int PAD_W    = DEF_PAD_W,
  parameter int PAD_XL   = DEF_PAD_XL,
  parameter int PAD_XR   = DEF_PAD_XR
) (
  input  logic [X_W-1:0] ball_x,
  input  logic [Y_W-1:0] ball_y,
  input  logic [Y_W-1:0] pad_l_y,
  input  logic [Y_W-1:0] pad_r_y,
  output logic           wall_hit,
  output logic           wall_clear,
  output logic           pad_hit,
  output logic           pad_clear,
  output logic           miss_l,
  output logic           miss_r
);

  localparam logic [CMP_W-1:0] BOT_Y   = CMP_W'(SCREEN_H - BALL_SZ);
  localparam logic [CMP_W-1:0] RIGHT_X = CMP_W'(SCREEN_W - BALL_SZ);
  localparam logic [CMP_W-1:0] XL      = CMP_W'(PAD_XL);
  localparam logic [CMP_W-1:0] XR      = CMP_W'(PAD_XR);
  localparam logic [CMP_W-1:0] PW      = CMP_W'(PAD_W);
  localparam logic [CMP_W-1:0] PH      = CMP_W'(PAD_H);
  localparam logic [CMP_W-1:0] BS      = CMP_W'(BALL_SZ);

  logic [CMP_W-1:0] bx, by, ly, ry;
  logic             xl_touch, xr_touch, yl_ovl, yr_ovl;

  assign bx = CMP_W'(ball_x);
  assign by = CMP_W'(ball_y);
  assign ly = CMP_W'(pad_l_y);
  assign ry = CMP_W'(pad_r_y);

  // Horizontal contact includes the ball resting flush against a paddle
  // face (e.g. ball_x == PAD_XL+PAD_W), which is where a bounce happens.
  function automatic logic x_touch(input logic [CMP_W-1:0] x,
                                   input logic [CMP_W-1:0] px);
    return (x <= px + PW) && (x + BS >= px);
  endfunction

  function automatic logic y_overlap(input logic [CMP_W-1:0] y,
                                     input logic [CMP_W-1:0] py);
    return (y < py + PH) && (y + BS > py);
  endfunction

  assign xl_touch = x_touch(bx, XL);
  assign xr_touch = x_touch(bx, XR);
  assign yl_ovl   = y_overlap(by, ly);
  assign yr_ovl   = y_overlap(by, ry);

  assign wall_hit   = (by == '0) || (by >= BOT_Y);
  assign wall_clear = (by != '0) && (by < BOT_Y);
  assign pad_hit    = (xl_touch && yl_ovl) || (xr_touch && yr_ovl);
  assign pad_clear  = !xl_touch && !xr_touch;
  assign miss_l     = (bx == '0);
  assign miss_r     = (bx >= RIGHT_X);

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-level sequencer for the pong ball datapath.
// Runs the IDLE/SERVE/PLAY/POINT/OVER flow, issues bounce pulses to the
// ball controller, keeps score and decides the winner.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   tick             : one-cycle frame/move strobe
//   start            : debounced start/serve level
//   ball_x, ball_y   : ball top-left position
//   pad_l_y, pad_r_y : paddle top positions
//   ball_en          : ball move enable (tick while playing)
//   ball_rst         : recentre request to the ball counters
//   v_col, h_col     : one-cycle vertical / horizontal bounce pulses
//   score_l, score_r : player scores (saturating at 15)
//   game_over        : high while the game is over
//   winner           : 0 = left, 1 = right; valid with game_over
//   state            : current FSM state encoding
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int BALL_SZ     = DEF_BALL_SZ,
  parameter int PAD_H       = DEF_PAD_H,
  parameter int PAD_W       = DEF_PAD_W,
  parameter int PAD_XL      = DEF_PAD_XL,
  parameter int PAD_XR      = DEF_PAD_XR,
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int PAUSE_TICKS = DEF_PAUSE_TICKS
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           start,
  input  logic [X_W-1:0] ball_x,
  input  logic [Y_W-1:0] ball_y,
  input  logic [Y_W-1:0] pad_l_y,
  input  logic [Y_W-1:0] pad_r_y,
  output logic           ball_en,
  output logic           ball_rst,
  output logic           v_col,
  output logic           h_col,
  output logic [3:0]     score_l,
  output logic [3:0]     score_r,
  output logic           game_over,
  output logic           winner,
  output logic [2:0]     state
);

  localparam int               CNT_W    = $clog2(PAUSE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAUSE_TICKS - 1);
  localparam logic [3:0]       WIN      = 4'(WIN_SCORE);

  state_t           cur, nxt;
  logic             start_q, start_edge;
  logic             v_arm, h_arm;
  logic [CNT_W-1:0] pause_cnt;
  logic             play_tick, won, miss, serve_entry;
  logic             ball_rst_d, game_over_d;
  logic             wall_hit, wall_clear, pad_hit, pad_clear, miss_l, miss_r;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'd15) ? s : s + 4'd1;
  endfunction

  pong_collide #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .BALL_SZ  (BALL_SZ),
    .PAD_H    (PAD_H),
    .PAD_W    (PAD_W),
    .PAD_XL   (PAD_XL),
    .PAD_XR   (PAD_XR)
  ) u_collide (
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .pad_l_y    (pad_l_y),
    .pad_r_y    (pad_r_y),
    .wall_hit   (wall_hit),
    .wall_clear (wall_clear),
    .pad_hit    (pad_hit),
    .pad_clear  (pad_clear),
    .miss_l     (miss_l),
    .miss_r     (miss_r)
  );

  assign start_edge  = start && !start_q;
  assign won         = (score_l == WIN) || (score_r == WIN);
  assign miss        = miss_l || miss_r;
  assign serve_entry = (nxt == ST_SERVE) && (cur != ST_SERVE);
  assign state       = cur;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= ST_IDLE;
    else        cur <= nxt;
  end

  // Next-state logic. In SERVE the registered ball_rst is high only on the
  // first cycle, so a tick on that cycle is deliberately not taken.
  always_comb begin
    nxt = cur;
    unique case (cur)
      ST_IDLE:  if (start_edge) nxt = ST_SERVE;
      ST_SERVE: if (tick && !ball_rst) nxt = ST_PLAY;
      ST_PLAY:  if (play_tick && miss) nxt = ST_POINT;
      ST_POINT: begin
        if (won)                                nxt = ST_OVER;
        else if (tick && pause_cnt == CNT_LAST) nxt = ST_SERVE;
      end
      ST_OVER:  if (start_edge) nxt = ST_SERVE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // Output decode: ball_en is the only combinational output; the rest are
  // next-values for the registered outputs, derived from the next state.
  always_comb begin
    play_tick   = tick && (cur == ST_PLAY);
    ball_en     = play_tick;
    ball_rst_d  = (nxt == ST_IDLE) || (nxt == ST_POINT) ||
                  (nxt == ST_OVER) || serve_entry;
    game_over_d = (nxt == ST_OVER);
  end

  // Registered outputs, arm flags, scores and pause counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q   <= 1'b0;
      ball_rst  <= 1'b1;
      game_over <= 1'b0;
      winner    <= 1'b0;
      v_col     <= 1'b0;
      h_col     <= 1'b0;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      pause_cnt <= '0;
      v_arm     <= 1'b1;
      h_arm     <= 1'b1;
    end else begin
      start_q   <= start;
      ball_rst  <= ball_rst_d;
      game_over <= game_over_d;
      v_col     <= 1'b0;
      h_col     <= 1'b0;

      if (play_tick) begin
        // Wall bounce is independent of the horizontal decision, so a
        // corner hit can raise both pulses on one tick.
        if (wall_hit && v_arm) begin
          v_col <= 1'b1;
          v_arm <= 1'b0;
        end else if (wall_clear) begin
          v_arm <= 1'b1;
        end

        // A miss suppresses any paddle bounce on the same tick.
        if (miss) begin
          if (miss_l) score_r <= sat_inc(score_r);
          else        score_l <= sat_inc(score_l);
        end else if (pad_hit && h_arm) begin
          h_col <= 1'b1;
          h_arm <= 1'b0;
        end else if (pad_clear) begin
          h_arm <= 1'b1;
        end
      end

      if (cur == ST_POINT) begin
        if (won)       winner    <= (score_r == WIN);
        else if (tick) pause_cnt <= (pause_cnt == CNT_LAST) ? '0 : pause_cnt + 1'b1;
      end

      if (cur == ST_OVER && start_edge) begin
        score_l <= 4'd0;
        score_r <= 4'd0;
      end

      if (serve_entry) begin
        v_arm <= 1'b1;
        h_arm <= 1'b1;
      end
    end
  end

endmodule
